instr_decode_stage: RTL and testbench
=====================================

# instr_decode_stage

Decode/issue stage between instruction fetch and `registerFile`. Accepts one 32-bit ARM instruction per cycle over a valid/ready handshake and latches it in a single decode slot. While the slot is occupied it drives the register file read addresses from the latched instruction. A 16-bit scoreboard holds an instruction until its source registers have no pending writes, then issues the decoded control fields and immediate to the execute stage.

## Interface
Parameters:
- `NUM_REGS`, 16, architectural register count; R15 (PC) is never scoreboarded.

Ports (reset is asynchronous, active-high; one clock):
- `clk`  in  1  rising-edge clock
- `reset`  in  1  async active-high; clears slot and scoreboard
- `instrIn`  in  32  fetched instruction
- `instrValid`  in  1  `instrIn` valid
- `instrReady`  out  1  slot can accept this cycle
- `readReg1`  out  4  to `registerFile` (Rn)
- `readReg2`  out  4  to `registerFile` (Rm for DP-register, Rd for STR, else 0)
- `issueValid`  out  1  slot full and hazard-free
- `issueReady`  in  1  execute stage accepts
- `issueOpClass`  out  2  0 DP, 1 MEM, 2 BR, 3 NOP/undefined
- `issueCond`  out  4  instr[31:28]
- `issueAluOp`  out  4  instr[24:21] for DP, else 0
- `issueIsImm`  out  1  DP with I=1, MEM with I=0, or BR
- `issueImm`  out  32  expanded immediate
- `issueWriteEnable`  out  1  instruction writes a register
- `issueDest`  out  4  destination register
- `issueSetFlags`  out  1  instr[20] for DP, else 0
- `wbValid`  in  1  writeback retiring a write this cycle
- `wbDest`  in  4  register being written back
- `flush`  in  1  taken branch; discard slot

## Operation
- Class from instr[27:26]: 00 DP, 01 MEM, 10 BR, 11 NOP (no write, no sources).
- Dest: DP writes Rd (instr[15:12]) except opcodes 1000–1011 (TST/TEQ/CMP/CMN). LDR (MEM, L=1) writes Rd, STR writes nothing. BL (BR, instr[24]=1) writes R14, B writes nothing.
- Immediates:
  - DP: zero-extend imm8 = instr[7:0], then rotate right by 2×instr[11:8].
  - MEM: zero-extend instr[11:0].
  - BR: sign-extend instr[23:0], then shift left 2.
- Sources used:
  - DP: Rn, except MOV/MVN (opcode 1101/1111). Rm when I=0.
  - MEM: Rn. Rd also used for STR.
  - BR, NOP: none.
- Hazard: any used source ≠ 15 whose scoreboard bit is set.
- States:
  - EMPTY: instrValid → FULL.
  - FULL: if hazard, stay, with issueValid=0. If no hazard and issueReady: fire.
    - On fire, go to FULL if instrValid, else EMPTY.
- instrReady = EMPTY or fire. This is a combinational path from issueReady, which is intentional for 1/cycle throughput.
- On fire with issueWriteEnable and issueDest≠15: set scoreboard[issueDest].
- wbValid clears scoreboard[wbDest]. If set and clear hit the same register in the same cycle, set wins.
- flush: slot → EMPTY next edge, with instrReady=0 and issueValid=0 that cycle. The scoreboard is untouched because in-flight writes still retire. flush has priority over instrValid and fire.
- readReg1/readReg2 are combinational from the latched instruction. The execute stage captures `readData1/2` on the fire cycle.

## Timing
- Reset: slot EMPTY, scoreboard 0. All outputs 0, except instrReady=1 once reset deasserts.
- Latency: accept at edge N → issueValid high in cycle N+1 if no hazard.
- Throughput: 1 instruction/cycle with no hazards and issueReady held high.
- RAW stall: a dependent instruction issues the cycle after the edge at which wbValid clears its source.
- Reset mid-stall discards the slot and clears the scoreboard.

## Structure
- Shared package `arm_pkg`:
  - op-class encodings
  - DP opcode constants (CMP, MOV, …)
  - `REG_PC=4'd15`, `REG_LR=4'd14`
- Sub-module `imm_expand`: combinational immediate expansion by class.

## Test plan
- Accept 0xE0821003 (ADD R1,R2,R3), issueReady=1 → next cycle: readReg1=2, readReg2=3, issueDest=1, issueWriteEnable=1, issueOpClass=0; scoreboard[1] set after fire.
- Then 0xE2814005 (ADD R4,R1,#5) → issueValid=0 until wbValid with wbDest=1; issues one cycle later with issueImm=5.
- 0xE3A004FF (MOV R0,#0xFF000000) → issueImm=0xFF000000, issueIsImm=1. 0xE3510000 (CMP) → issueWriteEnable=0, issueSetFlags=1.
- 0xE5965004 (LDR R5,[R6,#4]) → issueDest=5, issueImm=4. 0xE5865000 (STR) → readReg2=5, issueWriteEnable=0.
- 0xEB000002 (BL) → issueImm=8, issueDest=14. 0xEAFFFFFE (B) → issueImm=0xFFFFFFF8.
- Slot full, issueReady=0, then flush=1 with instrValid=1 → slot EMPTY, nothing issued, input not accepted. Also: simultaneous fire setting R3 and wbDest=3 → scoreboard[3] remains set.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared ARM decode definitions: op classes, data-processing opcodes and
// architectural register numbers used by the decode/issue stage.
package arm_pkg;

    typedef enum logic [1:0] {
        CLS_DP  = 2'd0,
        CLS_MEM = 2'd1,
        CLS_BR  = 2'd2,
        CLS_NOP = 2'd3
    } op_class_e;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_TST = 4'h8;
    localparam logic [3:0] OP_TEQ = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;
    localparam logic [3:0] OP_CMN = 4'hB;
    localparam logic [3:0] OP_MOV = 4'hD;
    localparam logic [3:0] OP_MVN = 4'hF;

    localparam logic [3:0] REG_PC = 4'd15;
    localparam logic [3:0] REG_LR = 4'd14;

    // TST/TEQ/CMP/CMN (10xx) only update flags.
    function automatic logic dp_writes_rd(input logic [3:0] opcode);
        return opcode[3:2] != 2'b10;
    endfunction

    function automatic logic dp_uses_rn(input logic [3:0] opcode);
        return (opcode != OP_MOV) && (opcode != OP_MVN);
    endfunction

endpackage

// File: rtl/imm_expand.sv
// Combinational immediate expansion for the DP, MEM and BR instruction classes.
module imm_expand
    import arm_pkg::*;
(
    input  logic [1:0]  opClass,
    input  logic [23:0] field,
    output logic [31:0] imm
);

    logic [31:0] dp_zext;
    logic [63:0] dp_rot;
    logic [4:0]  rot_amt;

    assign dp_zext = {24'd0, field[7:0]};
    assign rot_amt = {field[11:8], 1'b0};
    // Rotating a doubled copy right gives a rotate in the low word.
    assign dp_rot  = {dp_zext, dp_zext} >> rot_amt;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        imm = 32'd0;
        case (op_class_e'(opClass))
            CLS_DP:  imm = dp_rot[31:0];
            CLS_MEM: imm = {20'd0, field[11:0]};
            CLS_BR:  imm = {{6{field[23]}}, field, 2'b00};
            default: imm = 32'd0;
        endcase
    end

endmodule

// File: rtl/instr_decode_stage.sv
// Single-slot ARM decode/issue stage with a register scoreboard that holds
// an instruction until its sources have no pending writes.
module instr_decode_stage
    import arm_pkg::*;
#(
    parameter int NUM_REGS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instrIn,
    input  logic        instrValid,
    output logic        instrReady,
    output logic [3:0]  readReg1,
    output logic [3:0]  readReg2,
    output logic        issueValid,
    input  logic        issueReady,
    output logic [1:0]  issueOpClass,
    output logic [3:0]  issueCond,
    output logic [3:0]  issueAluOp,
    output logic        issueIsImm,
    output logic [31:0] issueImm,
    output logic        issueWriteEnable,
    output logic [3:0]  issueDest,
    output logic        issueSetFlags,
    input  logic        wbValid,
    input  logic [3:0]  wbDest,
    input  logic        flush
);

    slot_state_e         state, state_next;
    logic [31:0]         instr_q;
    logic [NUM_REGS-1:0] scoreboard;
    logic [NUM_REGS-1:0] sb_set, sb_clr;
    logic                full, load, fire, hazard;

    op_class_e   op_class;
    logic [3:0]  rn, rd, rm, opcode;
    logic        use_rn, use_rm, use_rd;
    logic        writes, is_imm;
    logic [3:0]  dest, rd2;
    logic [31:0] imm_raw;

    assign full   = (state == SLOT_FULL);
    assign rn     = instr_q[19:16];
    assign rd     = instr_q[15:12];
    assign rm     = instr_q[3:0];
    assign opcode = instr_q[24:21];

    always_comb begin
        op_class = op_class_e'(instr_q[27:26]);
        use_rn   = 1'b0;
        use_rm   = 1'b0;
        use_rd   = 1'b0;
        writes   = 1'b0;
        is_imm   = 1'b0;
        dest     = 4'd0;
        rd2      = 4'd0;
        case (op_class)
            CLS_DP: begin
                use_rn = dp_uses_rn(opcode);
                use_rm = !instr_q[25];
                writes = dp_writes_rd(opcode);
                dest   = writes ? rd : 4'd0;
                is_imm = instr_q[25];
                rd2    = instr_q[25] ? 4'd0 : rm;
            end
            CLS_MEM: begin
                use_rn = 1'b1;
                use_rd = !instr_q[20];
                writes = instr_q[20];
                dest   = instr_q[20] ? rd : 4'd0;
                is_imm = !instr_q[25];
                rd2    = instr_q[20] ? 4'd0 : rd;
            end
            CLS_BR: begin
                writes = instr_q[24];
                dest   = instr_q[24] ? REG_LR : 4'd0;
                is_imm = 1'b1;
            end
            default: ;
        endcase
    end

    imm_expand u_imm_expand (
        .opClass (instr_q[27:26]),
        .field   (instr_q[23:0]),
        .imm     (imm_raw)
    );

    // R15 is never tracked, so a PC source can never stall.
    assign hazard = (use_rn && rn != REG_PC && scoreboard[rn])
                  | (use_rm && rm != REG_PC && scoreboard[rm])
                  | (use_rd && rd != REG_PC && scoreboard[rd]);

    assign issueValid = full && !hazard && !flush;
    assign fire       = issueValid && issueReady;
    assign instrReady = !reset && !flush && (!full || fire);
    assign load       = instrValid && instrReady;

    // An empty slot presents all-zero decode outputs.
    assign readReg1         = full ? rn : 4'd0;
    assign readReg2         = full ? rd2 : 4'd0;
    assign issueOpClass     = full ? instr_q[27:26] : 2'd0;
    assign issueCond        = full ? instr_q[31:28] : 4'd0;
    assign issueAluOp       = (full && op_class == CLS_DP) ? opcode : 4'd0;
    assign issueIsImm       = full && is_imm;
    assign issueImm         = full ? imm_raw : 32'd0;
    assign issueWriteEnable = full && writes;
    assign issueDest        = full ? dest : 4'd0;
    assign issueSetFlags    = full && op_class == CLS_DP && instr_q[20];

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = SLOT_EMPTY;
        end else begin
            case (state)
                SLOT_EMPTY: if (instrValid) state_next = SLOT_FULL;
                SLOT_FULL:  if (fire) state_next = instrValid ? SLOT_FULL : SLOT_EMPTY;
                default:    state_next = SLOT_EMPTY;
            endcase
        end
    end

    assign sb_set = (fire && issueWriteEnable && issueDest != REG_PC)
                  ? (NUM_REGS'(1) << issueDest) : '0;
    assign sb_clr = wbValid ? (NUM_REGS'(1) << wbDest) : '0;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= SLOT_EMPTY;
            instr_q    <= 32'd0;
            scoreboard <= '0;
        end else begin
            state <= state_next;
            if (load) instr_q <= instrIn;
            // Set after clear so an issuing writer wins over a same-cycle retire.
            scoreboard <= (scoreboard & ~sb_clr) | sb_set;
        end
    end

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed self-checking bench for instr_decode_stage: decode fields,
// RAW stalls, throughput, flush and reset behaviour.
module tb_instr_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instrIn;
    logic        instrValid;
    logic        instrReady;
    logic [3:0]  readReg1, readReg2;
    logic        issueValid, issueReady;
    logic [1:0]  issueOpClass;
    logic [3:0]  issueCond, issueAluOp;
    logic        issueIsImm;
    logic [31:0] issueImm;
    logic        issueWriteEnable;
    logic [3:0]  issueDest;
    logic        issueSetFlags;
    logic        wbValid;
    logic [3:0]  wbDest;
    logic        flush;

    int vectors     = 0;
    int miscompares = 0;

    localparam logic [31:0] I_ADD_R1   = 32'hE0821003; // ADD R1,R2,R3
    localparam logic [31:0] I_ADDI_R4  = 32'hE2814005; // ADD R4,R1,#5
    localparam logic [31:0] I_ADD_R3   = 32'hE0823001; // ADD R3,R2,R1
    localparam logic [31:0] I_ADDI_R43 = 32'hE2834005; // ADD R4,R3,#5
    localparam logic [31:0] I_MOV      = 32'hE3A004FF; // MOV R0,#0xFF000000
    localparam logic [31:0] I_CMP      = 32'hE3510000; // CMP R1,#0
    localparam logic [31:0] I_LDR      = 32'hE5965004; // LDR R5,[R6,#4]
    localparam logic [31:0] I_STR      = 32'hE5865000; // STR R5,[R6]
    localparam logic [31:0] I_BL       = 32'hEB000002;
    localparam logic [31:0] I_B        = 32'hEAFFFFFE;
    localparam logic [31:0] I_NOP      = 32'hEC000000;

    instr_decode_stage #(.NUM_REGS(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .instrIn          (instrIn),
        .instrValid       (instrValid),
        .instrReady       (instrReady),
        .readReg1         (readReg1),
        .readReg2         (readReg2),
        .issueValid       (issueValid),
        .issueReady       (issueReady),
        .issueOpClass     (issueOpClass),
        .issueCond        (issueCond),
        .issueAluOp       (issueAluOp),
        .issueIsImm       (issueIsImm),
        .issueImm         (issueImm),
        .issueWriteEnable (issueWriteEnable),
        .issueDest        (issueDest),
        .issueSetFlags    (issueSetFlags),
        .wbValid          (wbValid),
        .wbDest           (wbDest),
        .flush            (flush)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        instrValid = 1'b0; instrIn = 32'd0; issueReady = 1'b0;
        wbValid = 1'b0; wbDest = 4'd0; flush = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        settle();
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (instrReady !== 1'b1) begin miscompares++; $display("FAIL reset_instrReady: got %b want 1", instrReady); end
        vectors++; if (issueValid !== 1'b0) begin miscompares++; $display("FAIL reset_issueValid: got %b want 0", issueValid); end
        vectors++; if (readReg1 !== 4'd0) begin miscompares++; $display("FAIL reset_readReg1: got %0d want 0", readReg1); end
        vectors++; if (issueWriteEnable !== 1'b0) begin miscompares++; $display("FAIL reset_we: got %b want 0", issueWriteEnable); end
        vectors++; if (issueImm !== 32'd0) begin miscompares++; $display("FAIL reset_imm: got %h want 0", issueImm); end
    endtask

    task automatic test_add_raw();
        do_reset();
        issueReady = 1'b1; instrIn = I_ADD_R1; instrValid = 1'b1;
        tick();
        instrIn = I_ADDI_R4;
        settle();
        vectors++; if (issueValid !== 1'b1) begin miscompares++; $display("FAIL add_valid: got %b want 1", issueValid); end
        vectors++; if (readReg1 !== 4'd2) begin miscompares++; $display("FAIL add_readReg1: got %0d want 2", readReg1); end
        vectors++; if (readReg2 !== 4'd3) begin miscompares++; $display("FAIL add_readReg2: got %0d want 3", readReg2); end
        vectors++; if (issueDest !== 4'd1) begin miscompares++; $display("FAIL add_dest: got %0d want 1", issueDest); end
        vectors++; if (issueWriteEnable !== 1'b1) begin miscompares++; $display("FAIL add_we: got %b want 1", issueWriteEnable); end
        vectors++; if (issueOpClass !== 2'd0) begin miscompares++; $display("FAIL add_class: got %0d want 0", issueOpClass); end
        vectors++; if (issueAluOp !== 4'h4) begin miscompares++; $display("FAIL add_aluop: got %h want 4", issueAluOp); end
        vectors++; if (issueIsImm !== 1'b0) begin miscompares++; $display("FAIL add_isimm: got %b want 0", issueIsImm); end
        vectors++; if (instrReady !== 1'b1) begin miscompares++; $display("FAIL add_fire_ready: got %b want 1", instrReady); end
        tick();
        instrValid = 1'b0;
        settle();
        vectors++; if (issueValid !== 1'b0) begin miscompares++; $display("FAIL raw_stall0: got %b want 0", issueValid); end
        vectors++; if (instrReady !== 1'b0) begin miscompares++; $display("FAIL raw_ready0: got %b want 0", instrReady); end
        vectors++; if (readReg1 !== 4'd1) begin miscompares++; $display("FAIL raw_readReg1: got %0d want 1", readReg1); end
        tick();
        vectors++; if (issueValid !== 1'b0) begin miscompares++; $display("FAIL raw_stall1: got %b want 0", issueValid); end
        wbValid = 1'b1; wbDest = 4'd1;
        settle();
        vectors++; if (issueValid !== 1'b0) begin miscompares++; $display("FAIL raw_wb_cycle: got %b want 0", issueValid); end
        tick();
        wbValid = 1'b0;
        settle();
        vectors++; if (issueValid !== 1'b1) begin miscompares++; $display("FAIL raw_release: got %b want 1", issueValid); end
        vectors++; if (issueImm !== 32'd5) begin miscompares++; $display("FAIL addi_imm: got %h want 5", issueImm); end
        vectors++; if (issueIsImm !== 1'b1) begin miscompares++; $display("FAIL addi_isimm: got %b want 1", issueIsImm); end
        vectors++; if (issueDest !== 4'd4) begin miscompares++; $display("FAIL addi_dest: got %0d want 4", issueDest); end
        tick();
        settle();
        vectors++; if (issueValid !== 1'b0) begin miscompares++; $display("FAIL raw_drained: got %b want 0", issueValid); end
        vectors++; if (instrReady !== 1'b1) begin miscompares++; $display("FAIL raw_empty_ready: got %b want 1", instrReady); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        issueReady = 1'b1; instrIn = I_MOV; instrValid = 1'b1;
        tick();
        instrIn = I_CMP;
        settle();
        vectors++; if (issueValid !== 1'b1) begin miscompares++; $display("FAIL mov_valid: got %b want 1", issueValid); end
        vectors++; if (issueImm !== 32'hFF000000) begin miscompares++; $display("FAIL mov_imm: got %h want ff000000", issueImm); end
        vectors++; if (issueIsImm !== 1'b1) begin miscompares++; $display("FAIL mov_isimm: got %b want 1", issueIsImm); end
        vectors++; if (issueAluOp !== 4'hD) begin miscompares++; $display("FAIL mov_aluop: got %h want d", issueAluOp); end
        vectors++; if (issueWriteEnable !== 1'b1) begin miscompares++; $display("FAIL mov_we: got %b want 1", issueWriteEnable); end
        vectors++; if (issueSetFlags !== 1'b0) begin miscompares++; $display("FAIL mov_s: got %b want 0", issueSetFlags); end
        tick();
        instrValid = 1'b0;
        settle();
        vectors++; if (issueValid !== 1'b1) begin miscompares++; $display("FAIL cmp_valid: got %b want 1", issueValid); end
        vectors++; if (issueWriteEnable !== 1'b0) begin miscompares++; $display("FAIL cmp_we: got %b want 0", issueWriteEnable); end
        vectors++; if (issueSetFlags !== 1'b1) begin miscompares++; $display("FAIL cmp_s: got %b want 1", issueSetFlags); end
        vectors++; if (issueAluOp !== 4'hA) begin miscompares++; $display("FAIL cmp_aluop: got %h want a", issueAluOp); end
        vectors++; if (readReg1 !== 4'd1) begin miscompares++; $display("FAIL cmp_readReg1: got %0d want 1", readReg1); end
        tick();
        settle();
        vectors++; if (issueValid !== 1'b0) begin miscompares++; $display("FAIL b2b_drained: got %b want 0", issueValid); end
    endtask

    task automatic test_mem();
        do_reset();
        issueReady = 1'b1; instrIn = I_LDR; instrValid = 1'b1;
        tick();
        instrIn = I_STR;
        settle();
        vectors++; if (issueValid !== 1'b1) begin miscompares++; $display("FAIL ldr_valid: got %b want 1", issueValid); end
        vectors++; if (issueOpClass !== 2'd1) begin miscompares++; $display("FAIL ldr_class: got %0d want 1", issueOpClass); end
        vectors++; if (issueDest !== 4'd5) begin miscompares++; $display("FAIL ldr_dest: got %0d want 5", issueDest); end
        vectors++; if (issueImm !== 32'd4) begin miscompares++; $display("FAIL ldr_imm: got %h want 4", issueImm); end
        vectors++; if (issueWriteEnable !== 1'b1) begin miscompares++; $display("FAIL ldr_we: got %b want 1", issueWriteEnable); end
        vectors++; if (readReg1 !== 4'd6) begin miscompares++; $display("FAIL ldr_readReg1: got %0d want 6", readReg1); end
        vectors++; if (issueAluOp !== 4'd0) begin miscompares++; $display("FAIL ldr_aluop: got %h want 0", issueAluOp); end
        tick();
        instrValid = 1'b0;
        settle();
        vectors++; if (readReg2 !== 4'd5) begin miscompares++; $display("FAIL str_readReg2: got %0d want 5", readReg2); end
        vectors++; if (issueWriteEnable !== 1'b0) begin miscompares++; $display("FAIL str_we: got %b want 0", issueWriteEnable); end
        vectors++; if (issueValid !== 1'b0) begin miscompares++; $display("FAIL str_rd_hazard: got %b want 0", issueValid); end
        wbValid = 1'b1; wbDest = 4'd5;
        tick();
        wbValid = 1'b0;
        settle();
        vectors++; if (issueValid !== 1'b1) begin miscompares++; $display("FAIL str_release: got %b want 1", issueValid); end
        vectors++; if (issueImm !== 32'd0) begin miscompares++; $display("FAIL str_imm: got %h want 0", issueImm); end
        tick();
    endtask

    task automatic test_branch();
        do_reset();
        issueReady = 1'b1; instrIn = I_BL; instrValid = 1'b1;
        tick();
        instrIn = I_B;
        settle();
        vectors++; if (issueValid !== 1'b1) begin miscompares++; $display("FAIL bl_valid: got %b want 1", issueValid); end
        vectors++; if (issueOpClass !== 2'd2) begin miscompares++; $display("FAIL bl_class: got %0d want 2", issueOpClass); end
        vectors++; if (issueImm !== 32'd8) begin miscompares++; $display("FAIL bl_imm: got %h want 8", issueImm); end
        vectors++; if (issueDest !== 4'd14) begin miscompares++; $display("FAIL bl_dest: got %0d want 14", issueDest); end
        vectors++; if (issueWriteEnable !== 1'b1) begin miscompares++; $display("FAIL bl_we: got %b want 1", issueWriteEnable); end
        vectors++; if (issueCond !== 4'hE) begin miscompares++; $display("FAIL bl_cond: got %h want e", issueCond); end
        tick();
        instrIn = I_NOP;
        settle();
        vectors++; if (issueValid !== 1'b1) begin miscompares++; $display("FAIL b_valid: got %b want 1", issueValid); end
        vectors++; if (issueImm !== 32'hFFFFFFF8) begin miscompares++; $display("FAIL b_imm: got %h want fffffff8", issueImm); end
        vectors++; if (issueWriteEnable !== 1'b0) begin miscompares++; $display("FAIL b_we: got %b want 0", issueWriteEnable); end
        tick();
        instrValid = 1'b0;
        settle();
        vectors++; if (issueOpClass !== 2'd3) begin miscompares++; $display("FAIL nop_class: got %0d want 3", issueOpClass); end
        vectors++; if (issueWriteEnable !== 1'b0) begin miscompares++; $display("FAIL nop_we: got %b want 0", issueWriteEnable); end
        vectors++; if (issueValid !== 1'b1) begin miscompares++; $display("FAIL nop_valid: got %b want 1", issueValid); end
        tick();
    endtask

    task automatic test_flush();
        do_reset();
        issueReady = 1'b0; instrIn = I_ADD_R1; instrValid = 1'b1;
        tick();
        instrIn = I_ADDI_R4;
        settle();
        vectors++; if (issueValid !== 1'b1) begin miscompares++; $display("FAIL flush_pre_valid: got %b want 1", issueValid); end
        vectors++; if (instrReady !== 1'b0) begin miscompares++; $display("FAIL flush_pre_ready: got %b want 0", instrReady); end
        flush = 1'b1;
        settle();
        vectors++; if (issueValid !== 1'b0) begin miscompares++; $display("FAIL flush_valid: got %b want 0", issueValid); end
        vectors++; if (instrReady !== 1'b0) begin miscompares++; $display("FAIL flush_ready: got %b want 0", instrReady); end
        tick();
        flush = 1'b0; instrValid = 1'b0; issueReady = 1'b1;
        settle();
        vectors++; if (issueValid !== 1'b0) begin miscompares++; $display("FAIL flush_empty_valid: got %b want 0", issueValid); end
        vectors++; if (instrReady !== 1'b1) begin miscompares++; $display("FAIL flush_empty_ready: got %b want 1", instrReady); end
        vectors++; if (readReg1 !== 4'd0) begin miscompares++; $display("FAIL flush_empty_rr1: got %0d want 0", readReg1); end
    endtask

    task automatic test_set_wins();
        do_reset();
        issueReady = 1'b1; instrIn = I_ADD_R3; instrValid = 1'b1;
        tick();
        instrIn = I_ADDI_R43; wbValid = 1'b1; wbDest = 4'd3;
        settle();
        vectors++; if (issueValid !== 1'b1) begin miscompares++; $display("FAIL setwin_fire: got %b want 1", issueValid); end
        tick();
        wbValid = 1'b0; instrValid = 1'b0;
        settle();
        vectors++; if (issueValid !== 1'b0) begin miscompares++; $display("FAIL setwin_stall0: got %b want 0", issueValid); end
        tick();
        vectors++; if (issueValid !== 1'b0) begin miscompares++; $display("FAIL setwin_stall1: got %b want 0", issueValid); end
        wbValid = 1'b1; wbDest = 4'd3;
        tick();
        wbValid = 1'b0;
        settle();
        vectors++; if (issueValid !== 1'b1) begin miscompares++; $display("FAIL setwin_release: got %b want 1", issueValid); end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        issueReady = 1'b1; instrIn = I_ADD_R1; instrValid = 1'b1;
        tick();
        instrIn = I_ADDI_R4;
        tick();
        instrValid = 1'b0;
        settle();
        vectors++; if (issueValid !== 1'b0) begin miscompares++; $display("FAIL midrst_stall: got %b want 0", issueValid); end
        reset = 1'b1;
        settle();
        vectors++; if (readReg1 !== 4'd0) begin miscompares++; $display("FAIL midrst_rr1: got %0d want 0", readReg1); end
        vectors++; if (instrReady !== 1'b0) begin miscompares++; $display("FAIL midrst_ready: got %b want 0", instrReady); end
        tick();
        reset = 1'b0;
        settle();
        vectors++; if (instrReady !== 1'b1) begin miscompares++; $display("FAIL midrst_after_ready: got %b want 1", instrReady); end
        instrValid = 1'b1;
        tick();
        instrValid = 1'b0;
        settle();
        vectors++; if (issueValid !== 1'b1) begin miscompares++; $display("FAIL midrst_sb_cleared: got %b want 1", issueValid); end
        tick();
    endtask

    initial begin
        test_reset();
        test_add_raw();
        test_back_to_back();
        test_mem();
        test_branch();
        test_flush();
        test_set_wins();
        test_reset_mid_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
